// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Column-serial AES MixColumns / InvMixColumns engine. A 128-bit state is
//   captured into a working register. COLS_PER_CYCLE columns are then mixed
//   in place on each clock until all four columns are done. The result is
//   held on out_data until the downstream stage accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data / in_inv are valid
//   in_ready   block can accept a state this cycle
//   in_data    input state, row-major: row r, col c = [127-32r-8c -: 8]
//   in_inv     0 = MixColumns, 1 = InvMixColumns (latched on acceptance)
//   out_valid  out_data holds a completed result
//   out_ready  downstream accepts out_data
//   out_data   result state, same byte layout as in_data
//   busy       high while columns are being mixed
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a state; in_ready high
// RUN   | mixing COLS_PER_CYCLE columns per clock, columns in order 0..3
// DONE  | result on out_data; a new state may be taken in the transfer cycle

module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // For COLS_PER_CYCLE=4 the step truncates to 0 and the last pass starts at
  // column 0, so the pointer simply stays at 0.
  localparam logic [1:0] CSTEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CLAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [1:0]   cptr_q, cptr_d;
  logic         inv_q, inv_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit coefficient. This covers every MixColumns and
  // InvMixColumns coefficient, using the byte and xtime^1..3 of it.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x1, x2, x3;
    x1 = xtime(b);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return ({8{k[0]}} & b) ^ ({8{k[1]}} & x1) ^ ({8{k[2]}} & x2) ^ ({8{k[3]}} & x3);
  endfunction

  // col = {s0, s1, s2, s3} (rows 0..3). Each matrix row is the previous one
  // rotated right, so the coefficient set k0..k3 is reused with rotation.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] s0, s1, s2, s3;
    logic [3:0] k0, k1, k2, k3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    if (inv) begin
      k0 = 4'he; k1 = 4'hb; k2 = 4'hd; k3 = 4'h9;
    end else begin
      k0 = 4'h2; k1 = 4'h3; k2 = 4'h1; k3 = 4'h1;
    end
    return {gmul(s0, k0) ^ gmul(s1, k1) ^ gmul(s2, k2) ^ gmul(s3, k3),
            gmul(s0, k3) ^ gmul(s1, k0) ^ gmul(s2, k1) ^ gmul(s3, k2),
            gmul(s0, k2) ^ gmul(s1, k3) ^ gmul(s2, k0) ^ gmul(s3, k1),
            gmul(s0, k1) ^ gmul(s1, k2) ^ gmul(s2, k3) ^ gmul(s3, k0)};
  endfunction

  logic [31:0]  col_cur [4];
  logic [31:0]  mix_out [COLS_PER_CYCLE];
  logic [127:0] work_upd;

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      col_cur[c] = {work_q[127-8*c -: 8], work_q[95-8*c -: 8],
                    work_q[63-8*c -: 8],  work_q[31-8*c -: 8]};
    end
  end

  genvar k;
  generate
    for (k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
      assign mix_out[k] = mix_col(col_cur[cptr_q + 2'(k)], inv_q);
    end
  endgenerate

  // Scatter the mixed columns back into their slots. All other columns keep
  // their current value.
  always_comb begin
    work_upd = work_q;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
        if (cptr_q + 2'(j) == 2'(c)) begin
          work_upd[127-8*c -: 8] = mix_out[j][31:24];
          work_upd[95-8*c -: 8]  = mix_out[j][23:16];
          work_upd[63-8*c -: 8]  = mix_out[j][15:8];
          work_upd[31-8*c -: 8]  = mix_out[j][7:0];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cptr_d    = cptr_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          inv_d   = in_inv;
          cptr_d  = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        work_d = work_upd;
        cptr_d = cptr_q + CSTEP;
        if (cptr_q == CLAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = in_data;
            inv_d   = in_inv;
            cptr_d  = 2'd0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= 128'h0;
      cptr_q  <= 2'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cptr_q  <= cptr_d;
      inv_q   <= inv_d;
    end
  end

  assign out_data = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq
//   Directed bench for mix_columns_seq. One instance is built for each legal
//   COLS_PER_CYCLE (1, 2, 4), and every instance has its own handshake
//   signals. Expected values are the known AES MixColumns test columns, and
//   random states are checked by a forward then inverse round trip.

module tb_mix_columns_seq;

  localparam logic [127:0] VA = 128'hdbf2012d_130a0126_53220131_455c014c;
  localparam logic [127:0] VB = 128'h8e9f014d_4ddc017e_a15801bd_bc9d01f8;
  localparam logic [127:0] VI = 128'h01c601c6_01c601c6_01c601c6_01c601c6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_inv    [3];
  logic         out_ready [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [127:0] in_data   [3];
  logic [127:0] out_data  [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid[g]),
        .in_ready (in_ready[g]),
        .in_data  (in_data[g]),
        .in_inv   (in_inv[g]),
        .out_valid(out_valid[g]),
        .out_ready(out_ready[g]),
        .out_data (out_data[g]),
        .busy     (busy[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one state to instance i with out_ready high and check the
  // acceptance, the latency to out_valid and the return to IDLE.
  task automatic xfer(input int i, input logic [127:0] d, input logic inv,
                      output logic [127:0] res);
    int cnt;
    @(negedge clk);
    in_valid[i]  = 1'b1;
    in_data[i]   = d;
    in_inv[i]    = inv;
    out_ready[i] = 1'b1;
    chk($sformatf("accept_rdy[%0d]", i), 128'(in_ready[i]), 128'd1);
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_inv[i]   = ~inv;
    in_data[i]  = ~d;
    cnt = 0;
    while (!out_valid[i] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk($sformatf("latency[%0d]", i), 128'(cnt), 128'(4 >> i));
    res = out_data[i];
    @(negedge clk);
    chk($sformatf("drained[%0d]", i), 128'(out_valid[i]), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] r1, r2, d;
    int cnt;
    int per;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_inv[i]    = 1'b0;
      out_ready[i] = 1'b0;
      in_data[i]   = 128'h0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i),  128'(in_ready[i]),  128'd1);
      chk($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'd0);
      chk($sformatf("rst_busy[%0d]", i),      128'(busy[i]),      128'd0);
      chk($sformatf("rst_out_data[%0d]", i),  out_data[i],        128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Forward vector and its inverse on every width
    for (int i = 0; i < 3; i++) begin
      xfer(i, VA, 1'b0, r1);
      chk($sformatf("fwd_data[%0d]", i), r1, VB);
      xfer(i, VB, 1'b1, r1);
      chk($sformatf("inv_data[%0d]", i), r1, VA);
    end

    // Identity columns in both modes
    for (int i = 0; i < 3; i++) begin
      xfer(i, VI, 1'b0, r1);
      chk($sformatf("ident_fwd[%0d]", i), r1, VI);
      xfer(i, VI, 1'b1, r1);
      chk($sformatf("ident_inv[%0d]", i), r1, VI);
    end

    // Backpressure on the narrowest instance
    @(negedge clk);
    in_valid[0]  = 1'b1;
    in_data[0]   = VA;
    in_inv[0]    = 1'b0;
    out_ready[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    cnt = 0;
    while (!out_valid[0] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_latency", 128'(cnt), 128'd4);
    for (int n = 0; n < 10; n++) begin
      in_valid[0] = 1'($urandom_range(0, 1));
      in_inv[0]   = 1'($urandom_range(0, 1));
      in_data[0]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
      chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
      chk("bp_out_data", out_data[0], VB);
      @(negedge clk);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_xfer_valid", 128'(out_valid[0]), 128'd0);
    chk("bp_no_capture_busy", 128'(busy[0]), 128'd0);
    chk("bp_idle_ready", 128'(in_ready[0]), 128'd1);

    // Back-to-back, alternating modes, on every width
    for (int i = 0; i < 3; i++) begin
      per = (4 >> i) + 1;
      @(negedge clk);
      out_ready[i] = 1'b1;
      in_valid[i]  = 1'b1;
      in_data[i]   = VA;
      in_inv[i]    = 1'b0;
      @(negedge clk);
      in_data[i] = VB;
      in_inv[i]  = 1'b1;
      cnt = 1;
      for (int k = 0; k < 4; k++) begin
        while (!out_valid[i] && cnt < 30) begin
          @(negedge clk);
          cnt++;
        end
        chk($sformatf("b2b_period[%0d][%0d]", i, k), 128'(cnt), 128'(per));
        chk($sformatf("b2b_data[%0d][%0d]", i, k), out_data[i], (k % 2 == 0) ? VB : VA);
        chk($sformatf("b2b_ready[%0d][%0d]", i, k), 128'(in_ready[i]), 128'd1);
        @(negedge clk);
        cnt = 1;
        if (k + 2 <= 3) begin
          in_data[i] = (k % 2 == 0) ? VA : VB;
          in_inv[i]  = (k % 2 == 0) ? 1'b0 : 1'b1;
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      chk($sformatf("b2b_end_valid[%0d]", i), 128'(out_valid[i]), 128'd0);
      chk($sformatf("b2b_end_busy[%0d]", i), 128'(busy[i]), 128'd0);
    end

    // Asynchronous reset during the second RUN cycle
    @(negedge clk);
    in_valid[0]  = 1'b1;
    in_data[0]   = VA;
    in_inv[0]    = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_run_busy", 128'(busy[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("arst_out_data", out_data[0], 128'h0);
    chk("arst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("arst_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_still_idle", 128'(out_valid[0]), 128'd0);
    xfer(0, VA, 1'b0, r1);
    chk("post_rst_data", r1, VB);

    // Random forward -> inverse round trips, spread over the three widths
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      xfer(n % 3, d, 1'b0, r1);
      xfer(n % 3, r1, 1'b1, r2);
      chk($sformatf("roundtrip[%0d]", n), r2, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
